// File: rtl/mem_burst_v3.sv
// mem_burst_v3: burst engine between the user burst interface and one
// Spartan-6 MCB user port. User bursts are cut into MCB commands of at most
// MAX_BL beats. Write data for a chunk is pushed before its command. Read
// commands are only issued while the read FIFO has room for the whole chunk.
//
// Optional build macro: MEM_BURST_RR_ARB_EN
//   defined   -> round-robin read/write arbitration (read first after reset)
//   undefined -> read has fixed priority over write
//
// Strobe semantics on every interface: a transfer happens on the rising edge
// of mem_clk where its strobe (cmd_en, wr_en, rd_en, wr_burst_data_req,
// rd_burst_data_valid) is high. A strobe is never raised while the matching
// "ready" input forbids it (cmd_full, wr_full, rd_empty), and the data it
// qualifies is valid in that same cycle.
module mem_burst_v3 #(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 27,
    parameter int LEN_BITS      = 10,
    parameter int MAX_BL        = 64,
    parameter int RD_FIFO_DEPTH = 64
) (
    input  logic                         rst,
    input  logic                         mem_clk,
    input  logic                         calib_done,
    input  logic                         rd_burst_req,
    input  logic                         wr_burst_req,
    input  logic [LEN_BITS-1:0]          rd_burst_len,
    input  logic [LEN_BITS-1:0]          wr_burst_len,
    input  logic [ADDR_BITS-1:0]         rd_burst_addr,
    input  logic [ADDR_BITS-1:0]         wr_burst_addr,
    input  logic [MEM_DATA_BITS-1:0]     wr_burst_data,
    output logic                         wr_burst_data_req,
    output logic [MEM_DATA_BITS-1:0]     rd_burst_data,
    output logic                         rd_burst_data_valid,
    output logic                         rd_burst_finish,
    output logic                         wr_burst_finish,
    output logic                         burst_finish,
    output logic                         err,
    output logic                         cmd_clk,
    output logic                         cmd_en,
    output logic [2:0]                   cmd_instr,
    output logic [5:0]                   cmd_bl,
    output logic [29:0]                  cmd_byte_addr,
    input  logic                         cmd_full,
    input  logic                         cmd_empty,
    output logic                         wr_clk,
    output logic                         wr_en,
    output logic [MEM_DATA_BITS/8-1:0]   wr_mask,
    output logic [MEM_DATA_BITS-1:0]     wr_data,
    input  logic                         wr_full,
    input  logic                         wr_empty,
    input  logic [6:0]                   wr_count,
    input  logic                         wr_underrun,
    input  logic                         wr_error,
    output logic                         rd_clk,
    output logic                         rd_en,
    input  logic [MEM_DATA_BITS-1:0]     rd_data,
    input  logic                         rd_full,
    input  logic                         rd_empty,
    input  logic [6:0]                   rd_count,
    input  logic                         rd_overflow,
    input  logic                         rd_error,
    output logic [2:0]                   state_dbg
);

    localparam int BYTE_SHIFT = $clog2(MEM_DATA_BITS / 8);
    localparam int OW         = $clog2(RD_FIFO_DEPTH + 1);
    localparam int SW         = ((LEN_BITS > OW) ? LEN_BITS : OW) + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_FILL = 3'd1,
        WR_CMD  = 3'd2,
        WR_END  = 3'd3,
        RD_CMD  = 3'd4,
        RD_WAIT = 3'd5,
        RD_END  = 3'd6
    } state_t;

    state_t               state, state_nxt;
    logic [LEN_BITS-1:0]  remaining;    // beats not yet covered by a command
    logic [LEN_BITS-1:0]  fill_cnt;     // beats pushed into the current write chunk
    logic [LEN_BITS-1:0]  rd_left;      // read beats still to pop from the MCB
    logic [29:0]          beat_addr;
    logic [OW-1:0]        outstanding;  // read beats commanded but not yet popped
    logic                 cmd_gap;      // a command was issued last cycle
    logic                 start_rd, start_wr;
    logic                 rd_first;

    logic [LEN_BITS-1:0]  chunk, chunk_m1;
    logic                 last_chunk, fill_last, rd_room, rd_issue;
    logic [29:0]          byte_addr;
    logic [SW-1:0]        rd_need;
    logic                 unused_status;

    assign cmd_clk = mem_clk;
    assign wr_clk  = mem_clk;
    assign rd_clk  = mem_clk;

    assign wr_mask           = '0;
    assign wr_data           = wr_burst_data;
    assign wr_burst_data_req = wr_en;
    assign burst_finish      = rd_burst_finish | wr_burst_finish;
    assign state_dbg         = state;
    assign unused_status     = ^{cmd_empty, wr_empty, wr_count, rd_full, rd_count};

    assign chunk      = (remaining > LEN_BITS'(MAX_BL)) ? LEN_BITS'(MAX_BL) : remaining;
    assign chunk_m1   = chunk - 1'b1;
    assign last_chunk = (remaining == chunk);
    assign fill_last  = ((fill_cnt + 1'b1) == chunk);
    assign byte_addr  = beat_addr << BYTE_SHIFT;
    assign rd_need    = SW'(outstanding) + SW'(chunk);
    assign rd_room    = (rd_need <= SW'(RD_FIFO_DEPTH));
    assign rd_issue   = cmd_en && (state == RD_CMD);

`ifdef MEM_BURST_RR_ARB_EN
    logic last_rd;

    // Remember which request type was granted last for round-robin.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst)           last_rd <= 1'b0;
        else if (start_rd) last_rd <= 1'b1;
        else if (start_wr) last_rd <= 1'b0;
    end

    assign rd_first = ~last_rd;
`else
    assign rd_first = 1'b1;
`endif

    // State register.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and strobe decode; everything freezes while calib_done is low.
    always_comb begin
        state_nxt     = state;
        cmd_en        = 1'b0;
        cmd_instr     = 3'b000;
        cmd_bl        = 6'd0;
        cmd_byte_addr = 30'd0;
        wr_en         = 1'b0;
        rd_en         = 1'b0;
        start_rd      = 1'b0;
        start_wr      = 1'b0;
        if (calib_done) begin
            case (state)
                IDLE: begin
                    // Wait out the finish pulse so a still-held request is not re-accepted.
                    if (!rd_burst_finish && !wr_burst_finish) begin
                        if (rd_burst_req && (!wr_burst_req || rd_first)) begin
                            start_rd  = 1'b1;
                            state_nxt = (rd_burst_len == '0) ? RD_END : RD_CMD;
                        end else if (wr_burst_req) begin
                            start_wr  = 1'b1;
                            state_nxt = (wr_burst_len == '0) ? WR_END : WR_FILL;
                        end
                    end
                end
                WR_FILL: begin
                    wr_en = ~wr_full;
                    if (wr_en && fill_last) state_nxt = WR_CMD;
                end
                WR_CMD: begin
                    cmd_bl        = chunk_m1[5:0];
                    cmd_byte_addr = byte_addr;
                    if (!cmd_full) begin
                        cmd_en    = 1'b1;
                        state_nxt = last_chunk ? WR_END : WR_FILL;
                    end
                end
                RD_CMD: begin
                    rd_en         = ~rd_empty && (rd_left != '0);
                    cmd_instr     = 3'b001;
                    cmd_bl        = chunk_m1[5:0];
                    cmd_byte_addr = byte_addr;
                    if (!cmd_full && !cmd_gap && rd_room) begin
                        cmd_en = 1'b1;
                        if (last_chunk) state_nxt = RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    rd_en = ~rd_empty && (rd_left != '0);
                    if (rd_left == '0) state_nxt = RD_END;
                end
                WR_END:  state_nxt = IDLE;
                RD_END:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Burst bookkeeping: latch a new burst, then advance per issued command.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            beat_addr <= '0;
        end else if (start_rd) begin
            remaining <= rd_burst_len;
            beat_addr <= 30'(rd_burst_addr);
        end else if (start_wr) begin
            remaining <= wr_burst_len;
            beat_addr <= 30'(wr_burst_addr);
        end else if (cmd_en) begin
            remaining <= remaining - chunk;
            beat_addr <= beat_addr + 30'(chunk);
        end
    end

    // Count write beats staged for the current chunk.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst)           fill_cnt <= '0;
        else if (start_wr) fill_cnt <= '0;
        else if (wr_en)    fill_cnt <= fill_last ? '0 : fill_cnt + 1'b1;
    end

    // Track read beats left to pop and beats in flight in the MCB read FIFO.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            rd_left     <= '0;
            outstanding <= '0;
            cmd_gap     <= 1'b0;
        end else begin
            cmd_gap <= cmd_en;
            if (start_rd)   rd_left <= rd_burst_len;
            else if (rd_en) rd_left <= rd_left - 1'b1;
            case ({rd_issue, rd_en})
                2'b10:   outstanding <= outstanding + OW'(chunk);
                2'b01:   outstanding <= outstanding - 1'b1;
                2'b11:   outstanding <= outstanding + OW'(chunk) - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Registered user read data, finish pulses and sticky error.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            rd_burst_data       <= '0;
            rd_burst_data_valid <= 1'b0;
            rd_burst_finish     <= 1'b0;
            wr_burst_finish     <= 1'b0;
            err                 <= 1'b0;
        end else begin
            rd_burst_data_valid <= rd_en;
            if (rd_en) rd_burst_data <= rd_data;
            rd_burst_finish <= calib_done && (state == RD_END);
            wr_burst_finish <= calib_done && (state == WR_END);
            err <= err | wr_underrun | wr_error | rd_overflow | rd_error;
        end
    end

endmodule

// File: tb/tb_mem_burst_v3.sv
// Bench for mem_burst_v3: behavioural MCB port model plus scoreboards for
// commands, write data and read data.
module tb_mem_burst_v3;

    logic        rst, mem_clk, calib_done;
    logic        rd_burst_req, wr_burst_req;
    logic [9:0]  rd_burst_len, wr_burst_len;
    logic [26:0] rd_burst_addr, wr_burst_addr;
    logic [63:0] wr_burst_data;
    logic        wr_burst_data_req;
    logic [63:0] rd_burst_data;
    logic        rd_burst_data_valid;
    logic        rd_burst_finish, wr_burst_finish, burst_finish, err;
    logic        cmd_clk, cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_full, cmd_empty;
    logic        wr_clk, wr_en;
    logic [7:0]  wr_mask;
    logic [63:0] wr_data;
    logic        wr_full, wr_empty;
    logic [6:0]  wr_count;
    logic        wr_underrun, wr_error;
    logic        rd_clk, rd_en;
    logic [63:0] rd_data;
    logic        rd_full, rd_empty;
    logic [6:0]  rd_count;
    logic        rd_overflow, rd_error;
    logic [2:0]  state_dbg;

    logic [38:0] cmd_exp_q[$];
    logic [63:0] wr_exp_q[$];
    logic [63:0] rd_exp_q[$];
    logic [63:0] rf_q[$];
    int          fin_log[$];

    int checks = 0;
    int failures = 0;
    int stall_left = 0, wr_req_cnt = 0, wr_user_idx = 0, cmd_cnt = 0;
    int rd_valid_cnt = 0, rd_fin_cnt = 0, wr_fin_cnt = 0;
    int mo = 0, mo_max = 0;
    int gap_viol = 0, stall_viol = 0, cmdfull_viol = 0, fifo_viol = 0, strobe_viol = 0;
    bit stall_armed = 0, rd_jitter = 0, cmd_jitter = 0, prev_cmd_en = 0;

    mem_burst_v3 dut (
        .rst(rst), .mem_clk(mem_clk), .calib_done(calib_done),
        .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
        .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
        .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data(wr_burst_data), .wr_burst_data_req(wr_burst_data_req),
        .rd_burst_data(rd_burst_data), .rd_burst_data_valid(rd_burst_data_valid),
        .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish),
        .burst_finish(burst_finish), .err(err),
        .cmd_clk(cmd_clk), .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full), .cmd_empty(cmd_empty),
        .wr_clk(wr_clk), .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data),
        .wr_full(wr_full), .wr_empty(wr_empty), .wr_count(wr_count),
        .wr_underrun(wr_underrun), .wr_error(wr_error),
        .rd_clk(rd_clk), .rd_en(rd_en), .rd_data(rd_data), .rd_full(rd_full),
        .rd_empty(rd_empty), .rd_count(rd_count), .rd_overflow(rd_overflow),
        .rd_error(rd_error), .state_dbg(state_dbg)
    );

    // Clock and watchdog.
    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wr_pat(input int i);
        logic [31:0] v;
        v = i;
        return {v * 32'h9E37_79B1, v ^ 32'h5A5A_0000};
    endfunction

    // Expected MCB commands for one user burst.
    task automatic push_cmds(input logic [2:0] instr, input int len, input int addr);
        int          rem;
        int          c;
        logic [29:0] a;
        rem = len;
        a   = 30'(addr);
        while (rem > 0) begin
            c = (rem > 64) ? 64 : rem;
            cmd_exp_q.push_back({instr, 6'(c - 1), a << 3});
            a   = a + 30'(c);
            rem = rem - c;
        end
    endtask

    task automatic do_write(input int len, input int addr);
        bit done;
        done = 0;
        push_cmds(3'b000, len, addr);
        wr_burst_len  = 10'(len);
        wr_burst_addr = 27'(addr);
        wr_burst_req  = 1'b1;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge mem_clk); #2;
            if (wr_burst_finish) done = 1;
        end
        wr_burst_req = 1'b0;
        check_eq("wr_burst_done", 64'(done), 64'd1);
    endtask

    task automatic do_read(input int len, input int addr);
        bit done;
        done = 0;
        push_cmds(3'b001, len, addr);
        rd_burst_len  = 10'(len);
        rd_burst_addr = 27'(addr);
        rd_burst_req  = 1'b1;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge mem_clk); #2;
            if (rd_burst_finish) done = 1;
        end
        rd_burst_req = 1'b0;
        check_eq("rd_burst_done", 64'(done), 64'd1);
    endtask

    // MCB port model and scoreboard: drive status at negedge, sample strobes 1 later.
    always @(negedge mem_clk) begin
        logic [63:0] d;
        cmd_full      = cmd_jitter && ($urandom_range(0, 3) == 0);
        wr_full       = (stall_left > 0);
        rd_empty      = (rf_q.size() == 0) || (rd_jitter && ($urandom_range(0, 1) == 0));
        rd_data       = (rf_q.size() != 0) ? rf_q[0] : 64'd0;
        wr_burst_data = wr_pat(wr_user_idx);
        #1;
        if (!rst) begin
            if (wr_full) begin
                if (wr_en || wr_burst_data_req) stall_viol++;
                stall_left--;
            end
            if (wr_en !== wr_burst_data_req) strobe_viol++;
            if (burst_finish !== (rd_burst_finish | wr_burst_finish)) strobe_viol++;
            if (wr_burst_data_req) begin
                wr_exp_q.push_back(wr_burst_data);
                wr_user_idx++;
                wr_req_cnt++;
                if (stall_armed && wr_req_cnt == 10) begin
                    stall_left  = 20;
                    stall_armed = 0;
                end
            end
            if (wr_en) begin
                if (wr_exp_q.size() == 0) check_eq("wr_data_extra", 64'(wr_exp_q.size()), 64'd1);
                else check_eq("wr_data", wr_data, wr_exp_q.pop_front());
            end
            if (cmd_en) begin
                if (prev_cmd_en) gap_viol++;
                if (cmd_full) cmdfull_viol++;
                cmd_cnt++;
                if (cmd_exp_q.size() == 0) check_eq("cmd_extra", 64'(cmd_exp_q.size()), 64'd1);
                else check_eq("cmd", 64'({cmd_instr, cmd_bl, cmd_byte_addr}), 64'(cmd_exp_q.pop_front()));
                if (cmd_instr == 3'b001) begin
                    for (int i = 0; i <= int'(cmd_bl); i++) begin
                        d = {$urandom, $urandom};
                        rf_q.push_back(d);
                        rd_exp_q.push_back(d);
                    end
                    mo = mo + int'(cmd_bl) + 1;
                end
            end
            if (mo > mo_max) mo_max = mo;
            if (rd_en) begin
                if (rd_empty) fifo_viol++;
                else begin
                    void'(rf_q.pop_front());
                    mo--;
                end
            end
            if (rd_burst_data_valid) begin
                rd_valid_cnt++;
                if (rd_exp_q.size() == 0) check_eq("rd_data_extra", 64'(rd_exp_q.size()), 64'd1);
                else check_eq("rd_data", rd_burst_data, rd_exp_q.pop_front());
            end
            if (rd_burst_finish) begin rd_fin_cnt++; fin_log.push_back(1); end
            if (wr_burst_finish) begin wr_fin_cnt++; fin_log.push_back(0); end
        end
        prev_cmd_en = cmd_en && !rst;
    end

    // Main sequence; all input changes happen 2 time units after a negedge.
    initial begin
        int b_req, b_cmd, b_fin, b_val, rd_done, wr_done;
        int exp_order[6];
        rst = 1'b1; calib_done = 1'b0;
        rd_burst_req = 0; wr_burst_req = 0;
        rd_burst_len = '0; wr_burst_len = '0; rd_burst_addr = '0; wr_burst_addr = '0;
        cmd_empty = 1'b1; wr_empty = 1'b1; wr_count = '0; wr_underrun = 0; wr_error = 0;
        rd_full = 0; rd_count = '0; rd_overflow = 0; rd_error = 0;
        repeat (2) @(negedge mem_clk); #2;

        check_eq("rst_cmd_en", 64'(cmd_en), 64'd0);
        check_eq("rst_wr_en", 64'(wr_en), 64'd0);
        check_eq("rst_rd_en", 64'(rd_en), 64'd0);
        check_eq("rst_data_req", 64'(wr_burst_data_req), 64'd0);
        check_eq("rst_rd_valid", 64'(rd_burst_data_valid), 64'd0);
        check_eq("rst_finish", 64'({rd_burst_finish, wr_burst_finish, burst_finish}), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_state", 64'(state_dbg), 64'd0);
        check_eq("rst_cmd_fields", 64'({cmd_instr, cmd_bl, cmd_byte_addr}), 64'd0);
        rst = 1'b0;

        // Requests are ignored until calibration completes.
        wr_burst_len = 10'd8; wr_burst_addr = 27'd0; wr_burst_req = 1'b1;
        repeat (5) @(negedge mem_clk); #2;
        check_eq("calib_hold_state", 64'(state_dbg), 64'd0);
        check_eq("calib_hold_cmds", 64'(cmd_cnt), 64'd0);
        check_eq("calib_hold_wr", 64'(wr_req_cnt), 64'd0);
        wr_burst_req = 1'b0;
        calib_done = 1'b1;
        repeat (2) @(negedge mem_clk); #2;

        // Long write with a 20-cycle wr_full stall inside the first chunk.
        b_req = wr_req_cnt; b_cmd = cmd_cnt; b_fin = wr_fin_cnt;
        stall_armed = 1;
        do_write(150, 'h100);
        check_eq("wr_beats", 64'(wr_req_cnt - b_req), 64'd150);
        check_eq("wr_cmds", 64'(cmd_cnt - b_cmd), 64'd3);
        check_eq("wr_finish_cnt", 64'(wr_fin_cnt - b_fin), 64'd1);
        check_eq("wr_stall_seen", 64'(stall_armed), 64'd0);
        check_eq("wr_stall_viol", 64'(stall_viol), 64'd0);
        repeat (3) @(negedge mem_clk); #2;

        // Long read with a jittery read FIFO and command FIFO.
        rd_jitter = 1; cmd_jitter = 1;
        b_val = rd_valid_cnt; b_fin = rd_fin_cnt; mo_max = 0;
        do_read(130, 'h2000);
        check_eq("rd_beats", 64'(rd_valid_cnt - b_val), 64'd130);
        check_eq("rd_finish_cnt", 64'(rd_fin_cnt - b_fin), 64'd1);
        check_eq("rd_outstanding_max", 64'(mo_max), 64'd64);
        check_eq("rd_exp_drained", 64'(rd_exp_q.size()), 64'd0);
        repeat (3) @(negedge mem_clk); #2;

        // Zero-length write: finish two cycles after the request, no command.
        b_cmd = cmd_cnt;
        wr_burst_len = 10'd0; wr_burst_addr = 27'h55; wr_burst_req = 1'b1;
        @(negedge mem_clk); #2;
        check_eq("len0_fin_early", 64'(wr_burst_finish), 64'd0);
        @(negedge mem_clk); #2;
        check_eq("len0_fin", 64'(wr_burst_finish), 64'd1);
        wr_burst_req = 1'b0;
        repeat (3) @(negedge mem_clk); #2;
        check_eq("len0_no_cmd", 64'(cmd_cnt - b_cmd), 64'd0);

        // Both requests held: three bursts each.
`ifdef MEM_BURST_RR_ARB_EN
        exp_order = '{1, 0, 1, 0, 1, 0};
`else
        exp_order = '{1, 1, 1, 0, 0, 0};
`endif
        begin
            int ri, wi;
            ri = 0; wi = 0;
            for (int k = 0; k < 6; k++) begin
                if (exp_order[k] == 1) begin push_cmds(3'b001, 8, 'h3000 + ri * 'h40); ri++; end
                else begin push_cmds(3'b000, 8, 'h4000 + wi * 'h40); wi++; end
            end
        end
        fin_log.delete();
        rd_done = 0; wr_done = 0;
        rd_burst_len = 10'd8; rd_burst_addr = 27'h3000; rd_burst_req = 1'b1;
        wr_burst_len = 10'd8; wr_burst_addr = 27'h4000; wr_burst_req = 1'b1;
        for (int cyc = 0; cyc < 5000 && (rd_done < 3 || wr_done < 3); cyc++) begin
            @(negedge mem_clk); #2;
            if (rd_burst_finish) begin
                rd_done++;
                if (rd_done < 3) rd_burst_addr = 27'('h3000 + rd_done * 'h40);
                else rd_burst_req = 1'b0;
            end
            if (wr_burst_finish) begin
                wr_done++;
                if (wr_done < 3) wr_burst_addr = 27'('h4000 + wr_done * 'h40);
                else wr_burst_req = 1'b0;
            end
        end
        rd_burst_req = 1'b0; wr_burst_req = 1'b0;
        check_eq("arb_done", 64'({rd_done[7:0], wr_done[7:0]}), 64'h0303);
        check_eq("arb_count", 64'(fin_log.size()), 64'd6);
        for (int k = 0; k < 6 && k < fin_log.size(); k++)
            check_eq($sformatf("arb_order_%0d", k), 64'(fin_log[k]), 64'(exp_order[k]));
        repeat (3) @(negedge mem_clk); #2;

        // Sticky error from a one-cycle rd_overflow.
        check_eq("err_before", 64'(err), 64'd0);
        rd_overflow = 1'b1;
        @(negedge mem_clk); #2;
        rd_overflow = 1'b0;
        check_eq("err_rise", 64'(err), 64'd1);
        repeat (10) @(negedge mem_clk); #2;
        check_eq("err_sticky", 64'(err), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("err_cleared", 64'(err), 64'd0);
        check_eq("rst_state_end", 64'(state_dbg), 64'd0);
        @(negedge mem_clk); #2;
        rst = 1'b0;

        // End-of-run scoreboard and protocol counters.
        check_eq("cmd_q_drained", 64'(cmd_exp_q.size()), 64'd0);
        check_eq("wr_q_drained", 64'(wr_exp_q.size()), 64'd0);
        check_eq("rd_q_drained", 64'(rd_exp_q.size()), 64'd0);
        check_eq("cmd_gap_viol", 64'(gap_viol), 64'd0);
        check_eq("cmd_full_viol", 64'(cmdfull_viol), 64'd0);
        check_eq("rd_empty_viol", 64'(fifo_viol), 64'd0);
        check_eq("strobe_viol", 64'(strobe_viol), 64'd0);
        check_eq("wr_mask", 64'(wr_mask), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
